// File: rtl/nubus_master.sv
`default_nettype none
// ============================================================================
// Module      : nubus_master
// Description : NuBus master transaction sequencer. Runs fair arbitration,
//               the address cycle and the data cycle for one local request at
//               a time, drives the active-low master strobes, tracks bus
//               occupancy from sensed START*/ACK* and supports locked
//               multi-transfer ownership ended by a NULL-ATTENTION cycle.
//               Optional macro NUBUS_MASTER_TIMEOUT_EN adds a data-cycle
//               watchdog limited by TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module nubus_master #(
    parameter int ARB_SETTLE = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic       nub_clkn,
    input  logic       nub_resetn,
    input  logic       cpu_valid,
    input  logic [1:0] cpu_tm,
    input  logic       cpu_lock,
    output logic       cpu_ready,
    output logic [1:0] cpu_status,
    output logic       cpu_timeout,
    input  logic       nub_startn,
    input  logic       nub_ackn,
    input  logic       nub_rqstn,
    input  logic       nub_tm1n,
    input  logic       nub_tm0n,
    input  logic       arb_won,
    output logic       mst_arbcyn,
    output logic       mst_adrcyn,
    output logic       mst_dtacyn,
    output logic       mst_ownern,
    output logic       mst_lockedn,
    output logic       mst_tm1n,
    output logic       mst_tm0n
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_LHOLD = 3'd4,
        S_NATTN = 3'd5
    } state_t;

    localparam logic [2:0] SETTLE_LIM = 3'(ARB_SETTLE);

    state_t     state_q,     state_d;
    logic       bus_busy_q,  bus_busy_d;
    logic [2:0] settle_q,    settle_d;
    logic       arbcyn_q,    arbcyn_d;
    logic       adrcyn_q,    adrcyn_d;
    logic       dtacyn_q,    dtacyn_d;
    logic       ownern_q,    ownern_d;
    logic       lockedn_q,   lockedn_d;
    logic [1:0] tmn_q,       tmn_d;
    logic       ready_q,     ready_d;
    logic [1:0] status_q,    status_d;
    logic       tmo_flag_d;
    logic       tmo_hit;
    logic       ack_seen;

`ifdef NUBUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_flag_q;

    // Watchdog fires on the TIMEOUT-th data clock without an ACK
    always_comb begin
        tmo_hit = (tmo_cnt_q == TMO_LIMIT);
    end
`else
    // TIMEOUT has no effect without the watchdog
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);

    // Without the watchdog the data cycle waits for the slave forever
    always_comb begin
        tmo_hit = 1'b0;
    end
`endif

    // Next-state, next-strobe and bus-occupancy computation
    always_comb begin
        state_d    = state_q;
        bus_busy_d = bus_busy_q;
        settle_d   = settle_q;
        arbcyn_d   = arbcyn_q;
        adrcyn_d   = adrcyn_q;
        dtacyn_d   = dtacyn_q;
        ownern_d   = ownern_q;
        lockedn_d  = lockedn_q;
        tmn_d      = tmn_q;
        ready_d    = 1'b0;
        status_d   = status_q;
        tmo_flag_d = 1'b0;
        ack_seen   = !nub_ackn;
`ifdef NUBUS_MASTER_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif

        // START with ACK together is an attention cycle: occupancy unchanged
        if (!nub_startn && nub_ackn) begin
            bus_busy_d = 1'b1;
        end else if (nub_startn && !nub_ackn) begin
            bus_busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // The request is still held during the cpu_ready cycle; a
                // request is only a new one from the following cycle.
                if (!ready_q && cpu_valid && nub_rqstn) begin
                    state_d  = S_ARB;
                    arbcyn_d = 1'b0;
                    settle_d = 3'd1;
                end
            end

            S_ARB: begin
                // settle_q is the index of the current settle clock
                if (!nub_startn) begin
                    settle_d = 3'd1;
                end else if (settle_q != 3'd7) begin
                    settle_d = settle_q + 3'd1;
                end
                if (nub_startn && (settle_q >= SETTLE_LIM) && arb_won && !bus_busy_q) begin
                    state_d   = S_ADDR;
                    ownern_d  = 1'b0;
                    adrcyn_d  = 1'b0;
                    tmn_d     = ~cpu_tm;
                    lockedn_d = ~cpu_lock;
                end
            end

            S_ADDR: begin
                // Any ACK seen here belongs to someone else and is ignored
                state_d  = S_DATA;
                adrcyn_d = 1'b1;
                dtacyn_d = 1'b0;
`ifdef NUBUS_MASTER_TIMEOUT_EN
                tmo_cnt_d = 8'd1;
`endif
            end

            S_DATA: begin
                if (ack_seen || tmo_hit) begin
                    ready_d    = 1'b1;
                    dtacyn_d   = 1'b1;
                    status_d   = ack_seen ? ~{nub_tm1n, nub_tm0n} : 2'b11;
                    tmo_flag_d = !ack_seen;
                    if (lockedn_q) begin
                        state_d  = S_IDLE;
                        ownern_d = 1'b1;
                        arbcyn_d = 1'b1;
                        tmn_d    = 2'b11;
                    end else if (ack_seen) begin
                        state_d = S_LHOLD;
                    end else begin
                        // A timed-out locked sequence is abandoned at once
                        state_d   = S_NATTN;
                        lockedn_d = 1'b1;
                    end
                end
`ifdef NUBUS_MASTER_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end

            S_LHOLD: begin
                // Bus stays owned; the next locked request skips arbitration
                if (!ready_q) begin
                    if (cpu_valid && cpu_lock) begin
                        state_d   = S_ADDR;
                        adrcyn_d  = 1'b0;
                        tmn_d     = ~cpu_tm;
                        lockedn_d = 1'b0;
                    end else if (!cpu_lock) begin
                        state_d   = S_NATTN;
                        lockedn_d = 1'b1;
                    end
                end
            end

            S_NATTN: begin
                state_d   = S_IDLE;
                arbcyn_d  = 1'b1;
                adrcyn_d  = 1'b1;
                dtacyn_d  = 1'b1;
                ownern_d  = 1'b1;
                lockedn_d = 1'b1;
                tmn_d     = 2'b11;
            end

            default: begin
                state_d   = S_IDLE;
                arbcyn_d  = 1'b1;
                adrcyn_d  = 1'b1;
                dtacyn_d  = 1'b1;
                ownern_d  = 1'b1;
                lockedn_d = 1'b1;
                tmn_d     = 2'b11;
            end
        endcase
    end

    // State and registered outputs; reset negates every strobe immediately
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q    <= S_IDLE;
            bus_busy_q <= 1'b0;
            settle_q   <= 3'd0;
            arbcyn_q   <= 1'b1;
            adrcyn_q   <= 1'b1;
            dtacyn_q   <= 1'b1;
            ownern_q   <= 1'b1;
            lockedn_q  <= 1'b1;
            tmn_q      <= 2'b11;
            ready_q    <= 1'b0;
            status_q   <= 2'b00;
`ifdef NUBUS_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= 8'd0;
            tmo_flag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bus_busy_q <= bus_busy_d;
            settle_q   <= settle_d;
            arbcyn_q   <= arbcyn_d;
            adrcyn_q   <= adrcyn_d;
            dtacyn_q   <= dtacyn_d;
            ownern_q   <= ownern_d;
            lockedn_q  <= lockedn_d;
            tmn_q      <= tmn_d;
            ready_q    <= ready_d;
            status_q   <= status_d;
`ifdef NUBUS_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
`endif
        end
    end

`ifdef NUBUS_MASTER_TIMEOUT_EN
    assign cpu_timeout = tmo_flag_q;
`else
    logic unused_tmo_flag;
    assign unused_tmo_flag = tmo_flag_d;
    assign cpu_timeout     = 1'b0;
`endif

    assign cpu_ready   = ready_q;
    assign cpu_status  = status_q;
    assign mst_arbcyn  = arbcyn_q;
    assign mst_adrcyn  = adrcyn_q;
    assign mst_dtacyn  = dtacyn_q;
    assign mst_ownern  = ownern_q;
    assign mst_lockedn = lockedn_q;
    assign mst_tm1n    = tmn_q[1];
    assign mst_tm0n    = tmn_q[0];

endmodule
`default_nettype wire

// File: tb/tb_nubus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_nubus_master
// Description : Directed self-checking bench for nubus_master. Strobe vector
//               order is {arbcyn, adrcyn, dtacyn, ownern, lockedn, tm1n, tm0n}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nubus_master;

    logic       clk;
    logic       rst_n;
    logic       cpu_valid;
    logic [1:0] cpu_tm;
    logic       cpu_lock;
    logic       cpu_ready;
    logic [1:0] cpu_status;
    logic       cpu_timeout;
    logic       nub_startn, nub_ackn, nub_rqstn, nub_tm1n, nub_tm0n, arb_won;
    logic       mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn;
    logic       mst_tm1n, mst_tm0n;
    logic [6:0] mst;

    int total = 0;
    int bad   = 0;

    nubus_master #(
        .ARB_SETTLE (2),
        .TIMEOUT    (16)
    ) u_dut (
        .nub_clkn    (clk),
        .nub_resetn  (rst_n),
        .cpu_valid   (cpu_valid),
        .cpu_tm      (cpu_tm),
        .cpu_lock    (cpu_lock),
        .cpu_ready   (cpu_ready),
        .cpu_status  (cpu_status),
        .cpu_timeout (cpu_timeout),
        .nub_startn  (nub_startn),
        .nub_ackn    (nub_ackn),
        .nub_rqstn   (nub_rqstn),
        .nub_tm1n    (nub_tm1n),
        .nub_tm0n    (nub_tm0n),
        .arb_won     (arb_won),
        .mst_arbcyn  (mst_arbcyn),
        .mst_adrcyn  (mst_adrcyn),
        .mst_dtacyn  (mst_dtacyn),
        .mst_ownern  (mst_ownern),
        .mst_lockedn (mst_lockedn),
        .mst_tm1n    (mst_tm1n),
        .mst_tm0n    (mst_tm0n)
    );

    assign mst = {mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn, mst_tm1n, mst_tm0n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, then check strobes and cpu_ready
    task automatic step(input string tag, input logic [6:0] exp_mst, input logic exp_rdy);
        tick();
        chk({tag, ".mst"}, {1'b0, mst}, {1'b0, exp_mst});
        chk({tag, ".rdy"}, {7'd0, cpu_ready}, {7'd0, exp_rdy});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n      = 1'b0;
        cpu_valid  = 1'b0;
        cpu_tm     = 2'b00;
        cpu_lock   = 1'b0;
        nub_startn = 1'b1;
        nub_ackn   = 1'b1;
        nub_rqstn  = 1'b1;
        nub_tm1n   = 1'b1;
        nub_tm0n   = 1'b1;
        arb_won    = 1'b0;

        // Reset state
        tick();
        chk("rst.mst", {1'b0, mst}, 8'h7F);
        chk("rst.rdy", {7'd0, cpu_ready}, 8'd0);
        chk("rst.sts", {6'd0, cpu_status}, 8'd0);
        chk("rst.tmo", {7'd0, cpu_timeout}, 8'd0);
        #2 rst_n = 1'b1;
        step("idle", 7'b1111111, 1'b0);

        // 1: basic unlocked transfer, tm=01, ACK in first data clock
        cpu_valid = 1'b1; cpu_tm = 2'b01; arb_won = 1'b1;
        step("t1.arb1", 7'b0111111, 1'b0);
        step("t1.arb2", 7'b0111111, 1'b0);
        step("t1.addr", 7'b0010110, 1'b0);
        step("t1.data", 7'b0100110, 1'b0);
        nub_ackn = 1'b0; nub_tm1n = 1'b0; nub_tm0n = 1'b0;
        step("t1.done", 7'b1111111, 1'b1);
        chk("t1.sts", {6'd0, cpu_status}, 8'd3);
        nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
        step("t1.after", 7'b1111111, 1'b0);
        chk("t1.hold", {6'd0, cpu_status}, 8'd3);
        cpu_valid = 1'b0;

        // 2: active request set blocks entry; ACK during ADDR is ignored
        nub_rqstn = 1'b0; cpu_valid = 1'b1; cpu_tm = 2'b00;
        for (int i = 0; i < 3; i++) step("t2.wait", 7'b1111111, 1'b0);
        nub_rqstn = 1'b1;
        step("t2.arb1", 7'b0111111, 1'b0);
        step("t2.arb2", 7'b0111111, 1'b0);
        step("t2.addr", 7'b0010111, 1'b0);
        nub_ackn = 1'b0; nub_tm1n = 1'b0; nub_tm0n = 1'b0;
        step("t2.data", 7'b0100111, 1'b0);
        nub_tm1n = 1'b1; nub_tm0n = 1'b0;
        step("t2.done", 7'b1111111, 1'b1);
        chk("t2.sts", {6'd0, cpu_status}, 8'd1);
        nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
        step("t2.after", 7'b1111111, 1'b0);
        cpu_valid = 1'b0;

        // 3: foreign START makes the bus busy; lose 6 clocks, then wait for ACK
        nub_startn = 1'b0;
        step("t3.fstart", 7'b1111111, 1'b0);
        nub_startn = 1'b1; cpu_valid = 1'b1; cpu_tm = 2'b11; arb_won = 1'b0;
        step("t3.arb", 7'b0111111, 1'b0);
        for (int i = 0; i < 6; i++) step("t3.lose", 7'b0111111, 1'b0);
        arb_won = 1'b1;
        for (int i = 0; i < 2; i++) step("t3.busy", 7'b0111111, 1'b0);
        nub_ackn = 1'b0;
        step("t3.fack", 7'b0111111, 1'b0);
        nub_ackn = 1'b1;
        step("t3.addr", 7'b0010100, 1'b0);
        step("t3.data", 7'b0100100, 1'b0);
        nub_ackn = 1'b0;
        step("t3.done", 7'b1111111, 1'b1);
        nub_ackn = 1'b1;
        step("t3.after", 7'b1111111, 1'b0);
        cpu_valid = 1'b0;

        // 4: locked pair then NULL-ATTENTION
        cpu_valid = 1'b1; cpu_lock = 1'b1; cpu_tm = 2'b10;
        step("t4.arb1", 7'b0111111, 1'b0);
        step("t4.arb2", 7'b0111111, 1'b0);
        step("t4.addr1", 7'b0010001, 1'b0);
        step("t4.data1", 7'b0100001, 1'b0);
        nub_ackn = 1'b0;
        step("t4.done1", 7'b0110001, 1'b1);
        nub_ackn = 1'b1;
        step("t4.hold1", 7'b0110001, 1'b0);
        cpu_tm = 2'b11;
        step("t4.addr2", 7'b0010000, 1'b0);
        step("t4.data2", 7'b0100000, 1'b0);
        nub_ackn = 1'b0;
        step("t4.done2", 7'b0110000, 1'b1);
        nub_ackn = 1'b1;
        step("t4.hold2", 7'b0110000, 1'b0);
        cpu_valid = 1'b0; cpu_lock = 1'b0;
        step("t4.nattn", 7'b0110100, 1'b0);
        step("t4.idle", 7'b1111111, 1'b0);

        // 5: reset mid-DATA negates strobes asynchronously, no completion
        cpu_valid = 1'b1; cpu_tm = 2'b01;
        step("t5.arb1", 7'b0111111, 1'b0);
        step("t5.arb2", 7'b0111111, 1'b0);
        step("t5.addr", 7'b0010110, 1'b0);
        step("t5.data", 7'b0100110, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.async", {1'b0, mst}, 8'h7F);
        chk("t5.rdy0", {7'd0, cpu_ready}, 8'd0);
        cpu_valid = 1'b0;
        step("t5.inrst", 7'b1111111, 1'b0);
        #2 rst_n = 1'b1;
        step("t5.idle", 7'b1111111, 1'b0);

`ifdef NUBUS_MASTER_TIMEOUT_EN
        // 6: watchdog ends a DATA cycle with no ACK after 16 clocks
        cpu_valid = 1'b1; cpu_tm = 2'b00;
        step("t6.arb1", 7'b0111111, 1'b0);
        step("t6.arb2", 7'b0111111, 1'b0);
        step("t6.addr", 7'b0010111, 1'b0);
        step("t6.data", 7'b0100111, 1'b0);
        for (int i = 0; i < 15; i++) step("t6.wait", 7'b0100111, 1'b0);
        step("t6.done", 7'b1111111, 1'b1);
        chk("t6.tmo", {7'd0, cpu_timeout}, 8'd1);
        chk("t6.sts", {6'd0, cpu_status}, 8'd3);
        step("t6.after", 7'b1111111, 1'b0);
        chk("t6.tmo0", {7'd0, cpu_timeout}, 8'd0);
        cpu_valid = 1'b0;
`else
        chk("t6.notmo", {7'd0, cpu_timeout}, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
